// File: rtl/l2_arb_pkg.sv
// Shared definitions for the L2 line-bus arbiter: FSM encoding, line width and offset mask.
package l2_arb_pkg;

  localparam int unsigned DMEM_LINE_W = 512;
  localparam int unsigned L2_LINE_W   = DMEM_LINE_W;

  localparam int unsigned LINE_OFF_W    = $clog2(L2_LINE_W / 8);
  localparam logic [63:0] LINE_OFF_MASK = 64'((64'd1 << LINE_OFF_W) - 64'd1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSetup = 2'd1,
    StRd    = 2'd2,
    StWr    = 2'd3
  } arb_state_e;

  function automatic logic [63:0] line_align(input logic [63:0] addr);
    return addr & ~LINE_OFF_MASK;
  endfunction

endpackage

// File: rtl/l2_arb_wbuf.sv
// Write-through line buffer: small FIFO of {addr, data} with a sticky overflow flag.
module l2_arb_wbuf #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned LINE_W = 512,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [LINE_W-1:0] push_data,
  output logic [ADDR_W-1:0] head_addr,
  output logic [LINE_W-1:0] head_data,
  output logic              full,
  output logic              empty,
  output logic              ovf
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]     cnt_q, cnt_d;
  logic              ovf_q;
  logic              do_push, do_pop;
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [LINE_W-1:0] data_mem [DEPTH];

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full      = (cnt_q == (PtrW + 1)'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign ovf       = ovf_q;
  assign head_addr = addr_mem[rd_ptr_q];
  assign head_data = data_mem[rd_ptr_q];

  // A push into a full buffer is only accepted when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + (PtrW + 1)'(1);
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - (PtrW + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      if (push && !do_push) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_mem[wr_ptr_q] <= push_addr;
      data_mem[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/l2_arb.sv
// Arbitrates the single L2 line bus between imem fills, dmem fills and buffered dmem writes.
module l2_arb
  import l2_arb_pkg::*;
#(
  parameter int unsigned LINE_W   = L2_LINE_W,
  parameter int unsigned WB_DEPTH = 2
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [63:0]       i_addr,
  input  logic              i_rd,
  output logic [LINE_W-1:0] i_data,
  output logic              i_dv,
  input  logic [63:0]       d_addr,
  input  logic              d_rd,
  output logic [LINE_W-1:0] d_data,
  output logic              d_dv,
  input  logic [LINE_W-1:0] d_wdata,
  input  logic              d_wr,
  output logic [63:0]       m_addr,
  output logic              m_rd,
  output logic              m_wr,
  output logic [LINE_W-1:0] m_wdata,
  input  logic [LINE_W-1:0] m_rdata,
  input  logic              m_dv,
  output logic              wb_full,
  output logic              wb_ovf
);

  arb_state_e        state_q, state_d;
  logic              gnt_dmem_q, gnt_dmem_d;
  logic              fav_dmem_q, fav_dmem_d;
  logic              pick_dmem;
  logic [63:0]       addr_q, addr_d;
  logic              wb_pop, wb_empty;
  logic [63:0]       wb_head_addr;
  logic [LINE_W-1:0] wb_head_data;

  l2_arb_wbuf #(
    .ADDR_W(64),
    .LINE_W(LINE_W),
    .DEPTH (WB_DEPTH)
  ) u_wbuf (
    .clk      (clk),
    .clr_n    (clr_n),
    .push     (d_wr),
    .pop      (wb_pop),
    .push_addr(line_align(d_addr)),
    .push_data(d_wdata),
    .head_addr(wb_head_addr),
    .head_data(wb_head_data),
    .full     (wb_full),
    .empty    (wb_empty),
    .ovf      (wb_ovf)
  );

  always_comb begin
    state_d    = state_q;
    gnt_dmem_d = gnt_dmem_q;
    fav_dmem_d = fav_dmem_q;
    addr_d     = addr_q;
    pick_dmem  = 1'b0;
    wb_pop     = 1'b0;
    m_rd       = 1'b0;
    m_wr       = 1'b0;
    m_addr     = '0;
    m_wdata    = '0;
    i_dv       = 1'b0;
    d_dv       = 1'b0;
    i_data     = '0;
    d_data     = '0;
    unique case (state_q)
      StIdle: begin
        // Draining writes first keeps every later read behind all buffered writes.
        if (!wb_empty) begin
          state_d = StWr;
        end else if (d_rd || i_rd) begin
          pick_dmem  = d_rd && (!i_rd || fav_dmem_q);
          gnt_dmem_d = pick_dmem;
          fav_dmem_d = !pick_dmem;
          state_d    = StSetup;
        end
      end
      StSetup: begin
        if (gnt_dmem_q ? d_rd : i_rd) begin
          addr_d  = line_align(gnt_dmem_q ? d_addr : i_addr);
          state_d = StRd;
        end else begin
          state_d = StIdle;
        end
      end
      StRd: begin
        m_rd   = 1'b1;
        m_addr = addr_q;
        if (m_dv) begin
          if (gnt_dmem_q) begin
            d_dv   = 1'b1;
            d_data = m_rdata;
          end else begin
            i_dv   = 1'b1;
            i_data = m_rdata;
          end
          state_d = StIdle;
        end
      end
      StWr: begin
        m_wr    = 1'b1;
        m_addr  = wb_head_addr;
        m_wdata = wb_head_data;
        if (m_dv) begin
          wb_pop  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= StIdle;
      gnt_dmem_q <= 1'b0;
      fav_dmem_q <= 1'b1;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      gnt_dmem_q <= gnt_dmem_d;
      fav_dmem_q <= fav_dmem_d;
      addr_q     <= addr_d;
    end
  end

endmodule

// File: tb/tb_l2_arb.sv
// Directed bench for l2_arb: table-driven read grants plus write, overflow, reset and drop cases.
module tb_l2_arb;

  localparam int unsigned LW = 512;

  logic          clk = 1'b0;
  logic          clr_n;
  logic [63:0]   i_addr, d_addr, m_addr;
  logic          i_rd, d_rd, i_dv, d_dv, d_wr, m_rd, m_wr, m_dv, wb_full, wb_ovf;
  logic [LW-1:0] i_data, d_data, d_wdata, m_wdata, m_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  l2_arb #(
    .LINE_W  (LW),
    .WB_DEPTH(2)
  ) dut (
    .clk    (clk),
    .clr_n  (clr_n),
    .i_addr (i_addr),
    .i_rd   (i_rd),
    .i_data (i_data),
    .i_dv   (i_dv),
    .d_addr (d_addr),
    .d_rd   (d_rd),
    .d_data (d_data),
    .d_dv   (d_dv),
    .d_wdata(d_wdata),
    .d_wr   (d_wr),
    .m_addr (m_addr),
    .m_rd   (m_rd),
    .m_wr   (m_wr),
    .m_wdata(m_wdata),
    .m_rdata(m_rdata),
    .m_dv   (m_dv),
    .wb_full(wb_full),
    .wb_ovf (wb_ovf)
  );

  typedef struct {
    logic        i_req;
    logic        d_req;
    logic [63:0] i_addr;
    logic [63:0] d_addr;
    logic [63:0] i_exp;
    logic [63:0] d_exp;
    logic [63:0] seed;
    logic        d_first;
  } rd_vec_t;

  rd_vec_t vecs[6];

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] mkline(input logic [63:0] seed);
    return {8{seed}};
  endfunction

  // Waits for m_rd, models an L2 with 3-cycle latency, then drops the served request.
  task automatic serve_read(input logic exp_d, input logic [63:0] exp_addr,
                            input logic [LW-1:0] data, input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!m_rd && n < 20);
    if (!m_rd) begin
      chk({tag, " m_rd timeout"}, 0, 1);
      return;
    end
    chk({tag, " latency"}, n, 2);
    chk({tag, " m_addr"}, m_addr, exp_addr);
    chk({tag, " m_wr"}, m_wr, 0);
    repeat (3) tick();
    m_rdata = data;
    m_dv    = 1'b1;
    #2;
    chk({tag, " granted dv"}, exp_d ? d_dv : i_dv, 1);
    chk({tag, " other dv"}, exp_d ? i_dv : d_dv, 0);
    chk({tag, " data"}, exp_d ? d_data : i_data, data);
    tick();
    m_dv = 1'b0;
    if (exp_d) d_rd = 1'b0;
    else i_rd = 1'b0;
    #2;
    chk({tag, " m_rd after dv"}, m_rd, 0);
    chk({tag, " dv after"}, i_dv | d_dv, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1, 1, 64'h3000, 64'h2000, 64'h3000, 64'h2000, 64'hAAAA_AAAA_AAAA_AAAA, 1};
    vecs[1] = '{1, 0, 64'h1000, 64'h0,    64'h1000, 64'h0,    64'hAAAA_5555_AAAA_5555, 0};
    vecs[2] = '{1, 1, 64'h3025, 64'h2040, 64'h3000, 64'h2040, 64'h0123_4567_89AB_CDEF, 1};
    vecs[3] = '{0, 1, 64'h0,    64'h5000, 64'h0,    64'h5000, 64'hDEAD_BEEF_0000_1111, 1};
    vecs[4] = '{1, 1, 64'h7000, 64'h6000, 64'h7000, 64'h6000, 64'h1357_9BDF_2468_ACE0, 0};
    vecs[5] = '{1, 1, 64'h7FC0, 64'h6FFF, 64'h7FC0, 64'h6FC0, 64'hFEDC_BA98_7654_3210, 0};

    clr_n = 1'b0; i_rd = 0; d_rd = 0; d_wr = 0; m_dv = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0;
    #2;
    chk("reset m_rd", m_rd, 0);
    chk("reset m_wr", m_wr, 0);
    chk("reset m_addr", m_addr, 0);
    chk("reset dv", {i_dv, d_dv}, 0);
    chk("reset wb_full", wb_full, 0);
    chk("reset wb_ovf", wb_ovf, 0);
    @(negedge clk);
    clr_n = 1'b1;
    tick();

    for (int v = 0; v < 6; v++) begin
      i_rd = vecs[v].i_req; i_addr = vecs[v].i_addr;
      d_rd = vecs[v].d_req; d_addr = vecs[v].d_addr;
      serve_read(vecs[v].d_first, vecs[v].d_first ? vecs[v].d_exp : vecs[v].i_exp,
                 mkline(vecs[v].seed), $sformatf("vec%0d first", v));
      if (vecs[v].i_req && vecs[v].d_req) begin
        serve_read(!vecs[v].d_first, vecs[v].d_first ? vecs[v].i_exp : vecs[v].d_exp,
                   ~mkline(vecs[v].seed), $sformatf("vec%0d second", v));
      end
    end

    // Buffered write must reach L2 before the later read to the same line.
    d_wr = 1'b1; d_addr = 64'h4010; d_wdata = mkline(64'h0D0D_0D0D_1234_5678);
    tick();
    d_wr = 1'b0; d_rd = 1'b1; d_addr = 64'h4000;
    begin
      int n;
      n = 0;
      do begin
        tick();
        n++;
      end while (!m_wr && !m_rd && n < 20);
    end
    chk("raw m_wr first", m_wr, 1);
    chk("raw m_rd low", m_rd, 0);
    chk("raw m_addr", m_addr, 64'h4000);
    chk("raw m_wdata", m_wdata, mkline(64'h0D0D_0D0D_1234_5678));
    tick(); tick();
    m_dv = 1'b1;
    tick();
    m_dv = 1'b0;
    serve_read(1'b1, 64'h4000, mkline(64'h5555_0000_5555_0000), "raw read");

    // Three writes into a 2-deep buffer with L2 stalled.
    tick();
    d_wr = 1'b1; d_addr = 64'h8000; d_wdata = mkline(64'h1111_0000_0000_0001);
    tick();
    d_addr = 64'h8040; d_wdata = mkline(64'h2222_0000_0000_0002);
    tick();
    #2;
    chk("ovf full", wb_full, 1);
    chk("ovf not yet", wb_ovf, 0);
    chk("ovf m_wr", m_wr, 1);
    chk("ovf head addr", m_addr, 64'h8000);
    d_addr = 64'h8080; d_wdata = mkline(64'h3333_0000_0000_0003);
    tick();
    d_wr = 1'b0;
    #2;
    chk("ovf set", wb_ovf, 1);
    chk("ovf still full", wb_full, 1);
    tick(); tick();
    m_dv = 1'b1;
    #2;
    chk("drain0 data", m_wdata, mkline(64'h1111_0000_0000_0001));
    tick();
    m_dv = 1'b0;
    #2;
    chk("drain0 idle gap", m_wr, 0);
    chk("drain0 not full", wb_full, 0);
    tick();
    #2;
    chk("drain1 m_wr", m_wr, 1);
    chk("drain1 addr", m_addr, 64'h8040);
    chk("drain1 data", m_wdata, mkline(64'h2222_0000_0000_0002));
    m_dv = 1'b1;
    tick();
    m_dv = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("dropped write absent %0d", k), m_wr, 0);
    end
    chk("ovf sticky", wb_ovf, 1);

    // Granted request withdrawn during SETUP: no L2 access.
    d_rd = 1'b1; d_addr = 64'hA000;
    tick();
    d_rd = 1'b0;
    tick();
    #2;
    chk("drop m_rd", m_rd, 0);
    chk("drop m_wr", m_wr, 0);
    i_rd = 1'b1; i_addr = 64'hB000;
    serve_read(1'b0, 64'hB000, mkline(64'h0BAD_F00D_0BAD_F00D), "after drop");

    // Reset in the middle of a read with a write pending.
    d_rd = 1'b1; d_addr = 64'h9000;
    tick(); tick();
    chk("rst pre m_rd", m_rd, 1);
    d_wr = 1'b1; d_addr = 64'h9100; d_wdata = mkline(64'h9999_9999_9999_9999);
    tick();
    d_wr = 1'b0;
    #2;
    clr_n = 1'b0;
    #1;
    chk("rst m_rd", m_rd, 0);
    chk("rst m_wr", m_wr, 0);
    chk("rst dv", {i_dv, d_dv}, 0);
    chk("rst ovf cleared", wb_ovf, 0);
    d_rd = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    tick();
    m_rdata = mkline(64'hEEEE_EEEE_EEEE_EEEE);
    m_dv = 1'b1;
    #2;
    chk("late dv ignored", {i_dv, d_dv}, 0);
    tick();
    m_dv = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("post rst idle %0d", k), {m_rd, m_wr}, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/l2_arb.md
Name: l2_arb

Overview:
- Arbitrates the single L2 line bus between the L1 instruction cache (imem) and the write-through L1 data cache (dmem) of one hart.
- Queues dmem write-through line writes in a small write buffer and serialises them with imem and dmem line-fill reads.
- Sits between the hart's L1 caches and the L2 cache port.

Parameters:
LINE_W, 512, cache line width in bits; must equal both the imem and dmem line widths.
WB_DEPTH, 2, write-buffer entries; power of two, at least 1.

Ports:
clk  in  1  clock
clr_n  in  1  asynchronous active-low reset
i_addr  in  64  imem line address; registered by imem, valid from the cycle after i_rd rises
i_rd  in  1  imem line-fill request; level, held until served
i_data  out  LINE_W  fill data to imem
i_dv  out  1  one-cycle fill-valid pulse to imem
d_addr  in  64  dmem line address; same timing rules as i_addr
d_rd  in  1  dmem line-fill request; level
d_data  out  LINE_W  fill data to dmem
d_dv  out  1  one-cycle fill-valid pulse to dmem
d_wdata  in  LINE_W  write-through line from dmem
d_wr  in  1  one-cycle write-through pulse; d_addr and d_wdata valid in that cycle
m_addr  out  64  L2 line address, low offset bits zero
m_rd  out  1  L2 read request; level, held until m_dv
m_wr  out  1  L2 write request; level, held until m_dv
m_wdata  out  LINE_W  L2 write data
m_rdata  in  LINE_W  L2 read data, valid with m_dv
m_dv  in  1  L2 completion pulse for both reads and writes
wb_full  out  1  write buffer holds WB_DEPTH entries
wb_ovf  out  1  sticky flag: a d_wr was dropped because the buffer was full

Behaviour:
- Reset (asynchronous, clr_n=0):
  - All outputs go to 0; m_rd and m_wr drop immediately.
  - FSM returns to IDLE.
  - Write buffer is emptied; wb_ovf is cleared; round-robin pointer is set to favour dmem.
  - An in-flight L2 transaction is abandoned. Any m_dv arriving after reset is released is ignored in IDLE.
- Write buffer: a FIFO of {addr, data}.
  - d_wr=1 with the buffer not full: push at the clock edge. The address is captured with the low offset bits forced to zero.
  - d_wr=1 with the buffer full: the write is dropped and wb_ovf is set to 1 until reset.
  - A push and a pop in the same cycle are both allowed, including when full; a push when full is legal only if a pop occurs in the same cycle.
  - Pointers wrap modulo WB_DEPTH. A 1-bit-wider count distinguishes full from empty.
- FSM states: IDLE, SETUP, RD, WR.
- IDLE: priority is write buffer not empty > reads.
  - Write buffer not empty: go to WR. m_addr/m_wdata are driven from the FIFO head; m_wr=1.
  - Otherwise, if d_rd or i_rd is high: grant one requester and go to SETUP.
    - Both high: round-robin; grant the one not served last. The pointer updates on each read grant.
    - Only one high: grant it.
- SETUP: one cycle so that the requester's registered address settles.
  - At the end of SETUP, m_addr is latched from the granted requester's address; go to RD with m_rd=1.
  - If the granted request has dropped during SETUP, return to IDLE with no L2 access.
- RD: hold m_rd and m_addr until m_dv.
  - On m_dv: route m_rdata to the granted requester's data output and pulse its dv for exactly one cycle, in the same cycle as m_dv (combinational data, registered grant).
  - m_rd deasserts the cycle after m_dv; go to IDLE.
  - The non-granted dv stays 0.
- WR: hold m_wr until m_dv. Pop the FIFO at the m_dv edge, then go to IDLE.
- Read-after-write ordering: the priority rule guarantees that every buffered write reaches L2 before any read granted later.
- The m_dv completion cycle is followed by at least one IDLE cycle. The requester's combinational rd held high with its dv is therefore never re-granted.
- m_rd and m_wr are never high together. m_dv outside RD/WR is ignored.
- Minimum read latency from rd rising: 2 cycles plus the L2 latency.

Decomposition:
- Shared package/header holds:
  - FSM state encodings: 2-bit localparams for IDLE, SETUP, RD, WR.
  - The line-width define, tied to the existing dmem line define.
  - The line-offset mask.
- One sub-module, l2_arb_wbuf: a parameterised synchronous FIFO with async clear, exposing push, pop, head, full, empty and ovf.

Test Plan:
1. Single imem read: i_rd=1 and i_addr=0x1000 from cycle 1; L2 returns m_dv 3 cycles after m_rd with data 0xAA... -> m_rd rises cycle 3 with m_addr=0x1000; i_dv pulses once with i_data=0xAA...; d_dv stays 0.
2. Simultaneous d_rd (0x2000) and i_rd (0x3000) from reset -> dmem served first, then imem. Repeating the pair alternates the grants.
3. d_wr pulse (addr 0x4010, data D) followed by d_rd to 0x4000 -> m_wr with m_addr=0x4000 and m_wdata=D completes before m_rd is issued.
4. Three back-to-back d_wr pulses with WB_DEPTH=2 and L2 stalled -> wb_full=1, the third write is dropped, wb_ovf=1; the two writes drain in order.
5. clr_n asserted while in RD with m_rd=1 -> m_rd=0 immediately, no dv pulses, buffer empty. A later m_dv is ignored.
6. Granted d_rd dropped during SETUP -> no L2 access; FSM back in IDLE the next cycle.
